donut_frame_sequencer: RTL
==========================

Name: donut_frame_sequencer

Overview:
Streams animation frames out of the 4-bit donut pixel ROM as a valid/ready pixel stream, one pixel per accepted beat. Each frame is a W×H block stored back-to-back in the ROM. The block sequences ROM reads, absorbs the 1-cycle ROM read latency under backpressure, and steps through frames on frame ticks. It sits between the ROM and the video scan-out/display path.

Parameters:
IMG_W, 400, pixels per line
IMG_H, 176, lines per frame
NUM_FRAMES, 1, frames stored consecutively in the ROM; must be 1..64
HOLD_TICKS, 2, frame_tick_i pulses each frame is shown before advancing; must be ≥1
ADDR_W, 32, ROM address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  pulse: begin playback
stop_i  in  1  pulse: finish current frame, then go idle
frame_tick_i  in  1  pulse per display frame (vsync-derived)
rom_cen_o  out  1  ROM read enable
rom_addr_o  out  ADDR_W  ROM read address
rom_data_i  in  4  ROM data, valid the cycle after rom_cen_o
pix_valid_o  out  1  pixel beat valid
pix_ready_i  in  1  downstream accept
pix_data_o  out  4  pixel value
pix_sof_o  out  1  first pixel of a frame, qualified by pix_valid_o
pix_eol_o  out  1  last pixel of a line, qualified by pix_valid_o
frame_idx_o  out  6  frame currently or last streamed
busy_o  out  1  state != IDLE
overrun_o  out  1  sticky: frame_tick_i arrived in STREAM/DRAIN

Behaviour:
- Reset: state IDLE; all outputs 0; frame_idx_o=0; hold counter=0; skid buffer emptied; any in-flight ROM data discarded. Reset during streaming has the same effect.
- FSM states: IDLE, WAIT_TICK, STREAM, DRAIN.
- IDLE: start_i moves to WAIT_TICK. If start_i and stop_i are both asserted, stop_i wins and the FSM stays in IDLE.
- WAIT_TICK: on frame_tick_i go to STREAM. Set the linear pixel counter to 0. Base address = frame_idx × IMG_W × IMG_H.
- STREAM: rom_addr_o = base + pixel counter. Issue a read (rom_cen_o=1) only when buffered + in-flight entries < 2, using a 2-entry skid buffer.
  - Each issued read increments the counter.
  - When the last pixel (IMG_W×IMG_H−1) is issued, go to DRAIN.
- DRAIN: wait until the skid buffer is empty and nothing is in flight. Then:
  - If stop is pending, go to IDLE.
  - Otherwise increment the hold counter and return to WAIT_TICK.
  - When the hold counter reaches HOLD_TICKS, advance frame_idx (wrap from NUM_FRAMES−1 to 0) and clear the hold counter.
- stop_i in WAIT_TICK: go to IDLE immediately. stop_i in STREAM/DRAIN: latch a pending flag and finish the frame first.
- Stream rules:
  - Once asserted, pix_valid_o, pix_data_o, pix_sof_o and pix_eol_o stay stable until pix_ready_i is high.
  - Pixels are emitted in ROM order with no loss or duplication.
  - Latency from the first rom_cen_o to the first pix_valid_o is 1 cycle.
  - Sustained throughput is 1 pixel/cycle while pix_ready_i=1.
- Pixel flags: pix_eol_o is set when (pixel index mod IMG_W) = IMG_W−1. pix_sof_o is set when pixel index = 0. Per-pixel column/sof tags travel alongside the data through the buffer.
- Address arithmetic: unsigned, ADDR_W bits. The maximum address NUM_FRAMES×IMG_W×IMG_H−1 must fit in ADDR_W.
- overrun_o: set by frame_tick_i in STREAM or DRAIN; that tick is otherwise ignored. Cleared only by reset.

Optional Feature:
DONUT_SEQ_PINGPONG_EN.
- Defined: frame order bounces 0,1,…,N−1,N−2,…,1,0,1,… using an internal direction bit (reset = up). With NUM_FRAMES=1 the index stays at 0.
- Not defined: the index wraps N−1 → 0.

Decomposition:
- Package donut_seq_pkg holds:
  - the state enum (IDLE, WAIT_TICK, STREAM, DRAIN);
  - localparam FRAME_PIX = IMG_W×IMG_H;
  - the function for frame base address.
- Sub-module donut_skid_buf: a 2-entry buffer holding {sof, eol, data[3:0]} with valid/ready and a count output used for read-issue gating.

Test Plan:
- IMG_W=4, IMG_H=2, NUM_FRAMES=3, HOLD_TICKS=1, ROM = pixel index mod 16, pix_ready_i=1. Stimulus: start, tick, tick, tick. Response: frame 0 data 0..7, frame 1 data 8..15, frame 2 data 0..7 (addresses 16..23). sof on the first beat of each frame; eol on beats 3 and 7.
- Same config, pix_ready_i toggling randomly 50%. Response: identical beat sequence, no drop or duplicate; outputs stable while valid && !ready; never more than 2 reads outstanding.
- HOLD_TICKS=2, NUM_FRAMES=2. Response: frame_idx_o sequence per streamed frame is 0,0,1,1,0.
- stop_i mid-STREAM of frame 1. Response: all 8 pixels of frame 1 delivered, then busy_o=0. start_i and stop_i together in IDLE: busy_o stays 0.
- frame_tick_i pulse during STREAM. Response: overrun_o=1 and stays 1; the stream is unaffected. rst_i mid-frame: next cycle pix_valid_o=0, busy_o=0, frame_idx_o=0, overrun_o=0.
- With DONUT_SEQ_PINGPONG_EN, NUM_FRAMES=3, HOLD_TICKS=1. Response: frame_idx_o sequence is 0,1,2,1,0,1.

Source files
------------

// File: rtl/donut_seq_pkg.sv
// Shared types and helpers for the donut frame sequencer.
// Build option: DONUT_SEQ_PINGPONG_EN selects bounce frame order.
package donut_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TICK,
      STREAM,
      DRAIN
   } seq_state_e;

   localparam int unsigned IMG_W_DEF = 400;
   localparam int unsigned IMG_H_DEF = 176;
   localparam int unsigned FRAME_PIX = IMG_W_DEF * IMG_H_DEF;

   // skid entry layout: {sof, eol, data[3:0]}
   localparam int ENT_W = 6;

   function automatic logic [31:0] frame_base(
      input logic [5:0]  idx,
      input logic [31:0] pix
   );
      return 32'(idx) * pix;
   endfunction

endpackage

// File: rtl/donut_skid_buf.sv
// Two-entry fall-through buffer between ROM read data and the pixel port.
// Build option: none (DONUT_SEQ_PINGPONG_EN lives in the top).
module donut_skid_buf
   import donut_seq_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid,
   input  logic [ENT_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ENT_W-1:0] out_data,
   output logic [1:0]       count
);

   logic [ENT_W-1:0] mem_q [2];
   logic [1:0]       cnt_q;
   logic             bypass;
   logic             push;
   logic             pop;

   // an empty buffer passes ROM data straight through when accepted
   assign bypass    = (cnt_q == 2'd0) && out_ready;
   assign push      = in_valid && !bypass;
   assign pop       = out_ready && (cnt_q != 2'd0);
   assign count     = cnt_q;
   assign out_valid = (cnt_q != 2'd0) || in_valid;
   assign out_data  = (cnt_q != 2'd0) ? mem_q[0] :
                      (in_valid ? in_data : '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= 2'd0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else if (push && pop) begin
         if (cnt_q == 2'd2) begin
            mem_q[0] <= mem_q[1];
            mem_q[1] <= in_data;
         end else begin
            mem_q[0] <= in_data;
         end
      end else if (pop) begin
         mem_q[0] <= mem_q[1];
         cnt_q    <= cnt_q - 2'd1;
      end else if (push) begin
         mem_q[cnt_q[0]] <= in_data;
         cnt_q           <= cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/donut_frame_sequencer.sv
// Streams donut animation frames from the pixel ROM as a valid/ready stream.
// Build option: DONUT_SEQ_PINGPONG_EN bounces frame order instead of wrapping.
module donut_frame_sequencer
   import donut_seq_pkg::*;
#(
   parameter int unsigned IMG_W      = 400,
   parameter int unsigned IMG_H      = 176,
   parameter int unsigned NUM_FRAMES = 1,
   parameter int unsigned HOLD_TICKS = 2,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              frame_tick_i,
   output logic              rom_cen_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [3:0]        rom_data_i,
   output logic              pix_valid_o,
   input  logic              pix_ready_i,
   output logic [3:0]        pix_data_o,
   output logic              pix_sof_o,
   output logic              pix_eol_o,
   output logic [5:0]        frame_idx_o,
   output logic              busy_o,
   output logic              overrun_o
);

   localparam int unsigned PIX_N = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX_N - 1);
   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
   localparam logic [5:0]        LAST_FRM = 6'(NUM_FRAMES - 1);
   localparam logic [15:0]       HOLD_N   = 16'(HOLD_TICKS);

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] pix_q, pix_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [5:0]        frm_q, frm_d;
   logic [15:0]       hold_q, hold_d;
   logic              stop_q, stop_d;
   logic              ovr_q, ovr_d;
   logic              infl_q, infl_d;
   logic              isof_q, isof_d;
   logic              ieol_q, ieol_d;
`ifdef DONUT_SEQ_PINGPONG_EN
   logic              dn_q, dn_d;
`endif
   logic [ADDR_W-1:0] base;
   logic [1:0]        sb_cnt;
   logic [ENT_W-1:0]  sb_out;
   logic              issue;

   assign base = ADDR_W'(frame_base(frm_q, 32'(PIX_N)));
   // buffered + in-flight must stay within the two skid slots
   assign issue = (sb_cnt == 2'd0) || ((sb_cnt == 2'd1) && !infl_q);

   donut_skid_buf u_skid (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .in_valid  (infl_q),
      .in_data   ({isof_q, ieol_q, rom_data_i}),
      .out_valid (pix_valid_o),
      .out_ready (pix_ready_i),
      .out_data  (sb_out),
      .count     (sb_cnt)
   );

   always_comb begin
      state_d    = state_q;
      pix_d      = pix_q;
      col_d      = col_q;
      frm_d      = frm_q;
      hold_d     = hold_q;
      stop_d     = stop_q;
      ovr_d      = ovr_q;
      infl_d     = 1'b0;
      isof_d     = 1'b0;
      ieol_d     = 1'b0;
`ifdef DONUT_SEQ_PINGPONG_EN
      dn_d       = dn_q;
`endif
      rom_cen_o  = 1'b0;
      rom_addr_o = '0;
      unique case (state_q)
         IDLE: begin
            if (start_i && !stop_i) state_d = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (stop_i) begin
               state_d = IDLE;
            end else if (frame_tick_i) begin
               state_d = STREAM;
               pix_d   = '0;
               col_d   = '0;
            end
         end
         STREAM: begin
            if (frame_tick_i) ovr_d = 1'b1;
            if (stop_i) stop_d = 1'b1;
            rom_addr_o = base + pix_q;
            if (issue) begin
               rom_cen_o = 1'b1;
               infl_d    = 1'b1;
               isof_d    = (pix_q == '0);
               ieol_d    = (col_q == LAST_COL);
               pix_d     = pix_q + ADDR_W'(1);
               col_d     = (col_q == LAST_COL) ? '0 : col_q + ADDR_W'(1);
               if (pix_q == LAST_PIX) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (frame_tick_i) ovr_d = 1'b1;
            if (stop_i) stop_d = 1'b1;
            if ((sb_cnt == 2'd0) && !infl_q) begin
               if (stop_q || stop_i) begin
                  state_d = IDLE;
                  stop_d  = 1'b0;
               end else begin
                  state_d = WAIT_TICK;
                  hold_d  = hold_q + 16'd1;
                  if ((hold_q + 16'd1) == HOLD_N) begin
                     hold_d = '0;
`ifdef DONUT_SEQ_PINGPONG_EN
                     if (LAST_FRM == 6'd0) begin
                        frm_d = 6'd0;
                     end else if (!dn_q) begin
                        if (frm_q == LAST_FRM) begin
                           frm_d = frm_q - 6'd1;
                           dn_d  = 1'b1;
                        end else begin
                           frm_d = frm_q + 6'd1;
                        end
                     end else begin
                        if (frm_q == 6'd0) begin
                           frm_d = 6'd1;
                           dn_d  = 1'b0;
                        end else begin
                           frm_d = frm_q - 6'd1;
                        end
                     end
`else
                     frm_d = (frm_q == LAST_FRM) ? 6'd0 : frm_q + 6'd1;
`endif
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pix_q   <= '0;
         col_q   <= '0;
         frm_q   <= '0;
         hold_q  <= '0;
         stop_q  <= 1'b0;
         ovr_q   <= 1'b0;
         infl_q  <= 1'b0;
         isof_q  <= 1'b0;
         ieol_q  <= 1'b0;
`ifdef DONUT_SEQ_PINGPONG_EN
         dn_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         col_q   <= col_d;
         frm_q   <= frm_d;
         hold_q  <= hold_d;
         stop_q  <= stop_d;
         ovr_q   <= ovr_d;
         infl_q  <= infl_d;
         isof_q  <= isof_d;
         ieol_q  <= ieol_d;
`ifdef DONUT_SEQ_PINGPONG_EN
         dn_q    <= dn_d;
`endif
      end
   end

   assign pix_sof_o   = sb_out[5];
   assign pix_eol_o   = sb_out[4];
   assign pix_data_o  = sb_out[3:0];
   assign frame_idx_o = frm_q;
   assign busy_o      = (state_q != IDLE);
   assign overrun_o   = ovr_q;

endmodule
